// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the game-phase timer: state encoding and small helpers.
package phase_sequencer_pkg;

    // Sequencer state encoding, shared with the display and game-logic blocks
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // True while a timeline is in progress (phases can still advance)
    function automatic logic is_active(input state_e st);
        return (st == ST_RUN) || (st == ST_PAUSED);
    endfunction

endpackage

// File: rtl/phase_sequencer.sv
// Game-phase timer: counts tick strobes and steps through NUM_PHASES phases of
// programmable length, with start/restart, pause, skip and phase-entry pulses.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int NUM_PHASES = 3,
    parameter int LEN_W      = 16,
    parameter int PHASE_W    = 3,
    parameter logic [(NUM_PHASES-1)*LEN_W-1:0] PHASE_LENS = {16'd30, 16'd6}
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               tick_i,
    input  logic               start_i,
    input  logic               pause_i,
    input  logic               skip_i,
    output logic [PHASE_W-1:0] phase_o,
    output logic [LEN_W-1:0]   phase_count_o,
    output logic [LEN_W-1:0]   remaining_o,
    output logic [LEN_W-1:0]   count_o,
    output logic               phase_start_o,
    output logic               running_o,
    output logic               done_o
);

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);
    // Programmed length of phase 0 with zero promoted to one tick
    localparam logic [LEN_W-1:0]   LEN0_RAW   = PHASE_LENS[LEN_W-1:0];
    localparam logic [LEN_W-1:0]   LEN0       = (LEN0_RAW == '0) ? LEN_W'(1) : LEN0_RAW;

    // Effective phase lengths; the terminal phase has no length
    logic [LEN_W-1:0] len_tab [NUM_PHASES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PHASES - 1; gi++) begin : g_len
            assign len_tab[gi] = (PHASE_LENS[gi*LEN_W +: LEN_W] == '0)
                               ? LEN_W'(1) : PHASE_LENS[gi*LEN_W +: LEN_W];
        end
    endgenerate
    assign len_tab[NUM_PHASES-1] = '0;

    state_e             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [LEN_W-1:0]   pc_q, pc_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic               ps_q, ps_d;
    logic               running_q, done_q;
    logic [LEN_W-1:0]   cur_len, next_len;
    logic               advance;

    // Length-select mux for the current phase and the phase being entered
    always_comb begin
        cur_len  = '0;
        next_len = '0;
        for (int k = 0; k < NUM_PHASES; k++) begin
            if (phase_q == PHASE_W'(k)) cur_len  = len_tab[k];
            if (phase_d == PHASE_W'(k)) next_len = len_tab[k];
        end
    end

    // Next-state logic: start > skip > pause > tick
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        pc_d    = pc_q;
        count_d = count_q;
        ps_d    = 1'b0;
        advance = 1'b0;

        if (start_i) begin
            state_d = ST_RUN;
            phase_d = '0;
            pc_d    = '0;
            count_d = '0;
            ps_d    = 1'b1;
        end else if (is_active(state_q)) begin
            if (skip_i) begin
                // Skip ends the phase like expiry but drops any coincident tick
                advance = 1'b1;
            end else if (state_q == ST_RUN) begin
                if (pause_i) begin
                    state_d = ST_PAUSED;
                end else if (tick_i) begin
                    count_d = (count_q == '1) ? count_q : count_q + LEN_W'(1);
                    if (pc_q + LEN_W'(1) == cur_len) begin
                        advance = 1'b1;
                    end else begin
                        pc_d = pc_q + LEN_W'(1);
                    end
                end
            end else if (!pause_i) begin
                state_d = ST_RUN;
            end
        end

        if (advance) begin
            phase_d = phase_q + PHASE_W'(1);
            pc_d    = '0;
            ps_d    = 1'b1;
            if (phase_d == LAST_PHASE) begin
                state_d = ST_DONE;
            end
        end

        // Terminal phase has zero length, so remaining reads 0 once DONE
        remaining_d = next_len - pc_d;
    end

    // State, counters and registered outputs
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            pc_q        <= '0;
            count_q     <= '0;
            remaining_q <= LEN0;
            ps_q        <= 1'b0;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            pc_q        <= pc_d;
            count_q     <= count_d;
            remaining_q <= remaining_d;
            ps_q        <= ps_d;
            running_q   <= (state_d == ST_RUN);
            done_q      <= (state_d == ST_DONE);
        end
    end

    assign phase_o       = phase_q;
    assign phase_count_o = pc_q;
    assign remaining_o   = remaining_q;
    assign count_o       = count_q;
    assign phase_start_o = ps_q;
    assign running_o     = running_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: default timeline plus a 4-bit variant
// with a zero-length phase and counter saturation.
module tb_phase_sequencer;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        tick_i = 1'b0, start_i = 1'b0, pause_i = 1'b0, skip_i = 1'b0;
    logic [2:0]  phase_o;
    logic [15:0] phase_count_o, remaining_o, count_o;
    logic        phase_start_o, running_o, done_o;

    logic        tick6 = 1'b0, start6 = 1'b0, pause6 = 1'b0, skip6 = 1'b0;
    logic [2:0]  phase6;
    logic [3:0]  pc6, rem6, count6;
    logic        ps6, run6, done6;

    int checks = 0;
    int errors = 0;

    always #5 clock_i = ~clock_i;

    phase_sequencer dut (
        .clock_i(clock_i), .reset_i(reset_i), .tick_i(tick_i), .start_i(start_i),
        .pause_i(pause_i), .skip_i(skip_i), .phase_o(phase_o),
        .phase_count_o(phase_count_o), .remaining_o(remaining_o), .count_o(count_o),
        .phase_start_o(phase_start_o), .running_o(running_o), .done_o(done_o)
    );

    phase_sequencer #(
        .NUM_PHASES(3), .LEN_W(4), .PHASE_W(3), .PHASE_LENS({4'd15, 4'd0})
    ) dut6 (
        .clock_i(clock_i), .reset_i(reset_i), .tick_i(tick6), .start_i(start6),
        .pause_i(pause6), .skip_i(skip6), .phase_o(phase6),
        .phase_count_o(pc6), .remaining_o(rem6), .count_o(count6),
        .phase_start_o(ps6), .running_o(run6), .done_o(done6)
    );

    // Advance one clock and land just after the edge for sampling
    task automatic cycle();
        @(posedge clock_i);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        cycle();
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (3) cycle();
        checks++;
        if (phase_o !== 3'd0 || count_o !== 16'd0 || phase_count_o !== 16'd0 ||
            phase_start_o !== 1'b0 || running_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got ph=%0d cnt=%0d pc=%0d ps=%0d run=%0d done=%0d exp all 0",
                     phase_o, count_o, phase_count_o, phase_start_o, running_o, done_o);
        end
        checks++;
        if (remaining_o !== 16'd6) begin
            errors++;
            $display("FAIL reset_remaining got %0d exp 6", remaining_o);
        end
        reset_i = 1'b0;
        tick_i = 1'b1; skip_i = 1'b1; pause_i = 1'b1;
        repeat (2) cycle();
        tick_i = 1'b0; skip_i = 1'b0; pause_i = 1'b0;
        cycle();
        checks++;
        if (count_o !== 16'd0 || phase_o !== 3'd0 || running_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignores got cnt=%0d ph=%0d run=%0d exp 0 0 0", count_o, phase_o, running_o);
        end
        $display("test_reset complete");
    endtask

    task automatic test_timeline();
        int ps_seen;
        int exp_ph, exp_pc, exp_rem;
        pulse_start();
        checks++;
        if (phase_start_o !== 1'b1 || running_o !== 1'b1 || phase_o !== 3'd0 || remaining_o !== 16'd6) begin
            errors++;
            $display("FAIL start_entry got ps=%0d run=%0d ph=%0d rem=%0d exp 1 1 0 6",
                     phase_start_o, running_o, phase_o, remaining_o);
        end
        ps_seen = 1;
        for (int i = 1; i <= 36; i++) begin
            tick_i = 1'b1;
            cycle();
            if (phase_start_o === 1'b1) ps_seen++;
            exp_ph  = (i < 6) ? 0 : (i < 36) ? 1 : 2;
            exp_pc  = (i < 6) ? i : (i < 36) ? i - 6 : 0;
            exp_rem = (i < 6) ? 6 - i : (i < 36) ? 30 - (i - 6) : 0;
            checks++;
            if (count_o !== 16'(i) || phase_o !== 3'(exp_ph) || phase_count_o !== 16'(exp_pc) ||
                remaining_o !== 16'(exp_rem)) begin
                errors++;
                $display("FAIL timeline_tick%0d got cnt=%0d ph=%0d pc=%0d rem=%0d exp %0d %0d %0d %0d",
                         i, count_o, phase_o, phase_count_o, remaining_o, i, exp_ph, exp_pc, exp_rem);
            end
        end
        checks++;
        if (done_o !== 1'b1 || running_o !== 1'b0) begin
            errors++;
            $display("FAIL timeline_done got done=%0d run=%0d exp 1 0", done_o, running_o);
        end
        checks++;
        if (ps_seen !== 3) begin
            errors++;
            $display("FAIL timeline_pulses got %0d exp 3", ps_seen);
        end
        repeat (3) cycle();
        tick_i = 1'b0;
        cycle();
        checks++;
        if (count_o !== 16'd36 || phase_o !== 3'd2 || phase_start_o !== 1'b0) begin
            errors++;
            $display("FAIL done_frozen got cnt=%0d ph=%0d ps=%0d exp 36 2 0", count_o, phase_o, phase_start_o);
        end
        $display("test_timeline complete");
    endtask

    task automatic test_pause();
        pulse_start();
        tick_i = 1'b1;
        repeat (10) cycle();
        pause_i = 1'b1;        // tick still high while pause rises
        cycle();
        checks++;
        if (running_o !== 1'b0 || count_o !== 16'd10) begin
            errors++;
            $display("FAIL pause_entry got run=%0d cnt=%0d exp 0 10", running_o, count_o);
        end
        repeat (5) cycle();
        checks++;
        if (count_o !== 16'd10 || phase_count_o !== 16'd4 || phase_o !== 3'd1) begin
            errors++;
            $display("FAIL pause_hold got cnt=%0d pc=%0d ph=%0d exp 10 4 1", count_o, phase_count_o, phase_o);
        end
        tick_i = 1'b0;
        pause_i = 1'b0;
        cycle();
        checks++;
        if (running_o !== 1'b1 || count_o !== 16'd10) begin
            errors++;
            $display("FAIL pause_release got run=%0d cnt=%0d exp 1 10", running_o, count_o);
        end
        tick_i = 1'b1;
        cycle();
        tick_i = 1'b0;
        checks++;
        if (count_o !== 16'd11 || phase_count_o !== 16'd5) begin
            errors++;
            $display("FAIL pause_resume got cnt=%0d pc=%0d exp 11 5", count_o, phase_count_o);
        end
        $display("test_pause complete");
    endtask

    task automatic test_skip();
        pulse_start();
        tick_i = 1'b1;
        repeat (3) cycle();
        skip_i = 1'b1;         // tick in the same cycle is dropped
        cycle();
        skip_i = 1'b0;
        tick_i = 1'b0;
        checks++;
        if (phase_o !== 3'd1 || phase_count_o !== 16'd0 || count_o !== 16'd3 ||
            remaining_o !== 16'd30 || phase_start_o !== 1'b1 || running_o !== 1'b1) begin
            errors++;
            $display("FAIL skip_run got ph=%0d pc=%0d cnt=%0d rem=%0d ps=%0d run=%0d exp 1 0 3 30 1 1",
                     phase_o, phase_count_o, count_o, remaining_o, phase_start_o, running_o);
        end
        skip_i = 1'b1;
        cycle();
        checks++;
        if (done_o !== 1'b1 || phase_o !== 3'd2 || remaining_o !== 16'd0 || count_o !== 16'd3) begin
            errors++;
            $display("FAIL skip_to_done got done=%0d ph=%0d rem=%0d cnt=%0d exp 1 2 0 3",
                     done_o, phase_o, remaining_o, count_o);
        end
        cycle();               // skip held in DONE
        skip_i = 1'b0;
        checks++;
        if (phase_o !== 3'd2 || phase_start_o !== 1'b0 || done_o !== 1'b1) begin
            errors++;
            $display("FAIL skip_in_done got ph=%0d ps=%0d done=%0d exp 2 0 1", phase_o, phase_start_o, done_o);
        end
        // Skip while paused keeps PAUSED until the terminal phase
        pulse_start();
        pause_i = 1'b1;
        cycle();
        skip_i = 1'b1;
        cycle();
        skip_i = 1'b0;
        checks++;
        if (phase_o !== 3'd1 || running_o !== 1'b0 || done_o !== 1'b0 || phase_start_o !== 1'b1) begin
            errors++;
            $display("FAIL skip_paused got ph=%0d run=%0d done=%0d ps=%0d exp 1 0 0 1",
                     phase_o, running_o, done_o, phase_start_o);
        end
        skip_i = 1'b1;
        cycle();
        skip_i = 1'b0;
        pause_i = 1'b0;
        checks++;
        if (done_o !== 1'b1 || phase_o !== 3'd2) begin
            errors++;
            $display("FAIL skip_paused_done got done=%0d ph=%0d exp 1 2", done_o, phase_o);
        end
        cycle();
        $display("test_skip complete");
    endtask

    task automatic test_restart();
        pulse_start();         // from DONE
        checks++;
        if (phase_o !== 3'd0 || count_o !== 16'd0 || phase_start_o !== 1'b1 ||
            running_o !== 1'b1 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL restart_done got ph=%0d cnt=%0d ps=%0d run=%0d done=%0d exp 0 0 1 1 0",
                     phase_o, count_o, phase_start_o, running_o, done_o);
        end
        tick_i = 1'b1;
        repeat (2) cycle();
        start_i = 1'b1;        // tick coincident with start is dropped
        cycle();
        start_i = 1'b0;
        tick_i = 1'b0;
        checks++;
        if (phase_o !== 3'd0 || count_o !== 16'd0 || phase_count_o !== 16'd0 ||
            phase_start_o !== 1'b1 || remaining_o !== 16'd6) begin
            errors++;
            $display("FAIL restart_tick got ph=%0d cnt=%0d pc=%0d ps=%0d rem=%0d exp 0 0 0 1 6",
                     phase_o, count_o, phase_count_o, phase_start_o, remaining_o);
        end
        $display("test_restart complete");
    endtask

    task automatic test_async_reset();
        pulse_start();
        tick_i = 1'b1;
        repeat (8) cycle();
        tick_i = 1'b0;
        checks++;
        if (phase_o !== 3'd1 || count_o !== 16'd8) begin
            errors++;
            $display("FAIL pre_reset got ph=%0d cnt=%0d exp 1 8", phase_o, count_o);
        end
        #2;
        reset_i = 1'b1;        // mid-cycle, well before the next edge
        #1;
        checks++;
        if (phase_o !== 3'd0 || count_o !== 16'd0 || phase_count_o !== 16'd0 ||
            running_o !== 1'b0 || remaining_o !== 16'd6) begin
            errors++;
            $display("FAIL async_clear got ph=%0d cnt=%0d pc=%0d run=%0d rem=%0d exp 0 0 0 0 6",
                     phase_o, count_o, phase_count_o, running_o, remaining_o);
        end
        cycle();
        reset_i = 1'b0;
        tick_i = 1'b1;
        repeat (4) cycle();
        tick_i = 1'b0;
        checks++;
        if (count_o !== 16'd0 || running_o !== 1'b0 || phase_start_o !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle got cnt=%0d run=%0d ps=%0d exp 0 0 0", count_o, running_o, phase_start_o);
        end
        $display("test_async_reset complete");
    endtask

    task automatic test_zero_len_saturate();
        start6 = 1'b1;
        cycle();
        start6 = 1'b0;
        tick6 = 1'b1;
        cycle();
        checks++;
        if (phase6 !== 3'd1 || count6 !== 4'd1 || pc6 !== 4'd0 || rem6 !== 4'd15 || ps6 !== 1'b1) begin
            errors++;
            $display("FAIL zero_len got ph=%0d cnt=%0d pc=%0d rem=%0d ps=%0d exp 1 1 0 15 1",
                     phase6, count6, pc6, rem6, ps6);
        end
        repeat (14) cycle();   // tick 15
        checks++;
        if (count6 !== 4'd15 || phase6 !== 3'd1 || pc6 !== 4'd14 || done6 !== 1'b0) begin
            errors++;
            $display("FAIL sat_tick15 got cnt=%0d ph=%0d pc=%0d done=%0d exp 15 1 14 0",
                     count6, phase6, pc6, done6);
        end
        cycle();               // tick 16
        checks++;
        if (count6 !== 4'd15 || phase6 !== 3'd2 || done6 !== 1'b1 || rem6 !== 4'd0) begin
            errors++;
            $display("FAIL sat_done got cnt=%0d ph=%0d done=%0d rem=%0d exp 15 2 1 0",
                     count6, phase6, done6, rem6);
        end
        repeat (2) cycle();
        tick6 = 1'b0;
        checks++;
        if (count6 !== 4'd15 || phase6 !== 3'd2 || run6 !== 1'b0) begin
            errors++;
            $display("FAIL sat_hold got cnt=%0d ph=%0d run=%0d exp 15 2 0", count6, phase6, run6);
        end
        $display("test_zero_len_saturate complete");
    endtask

    initial begin
        test_reset();
        test_timeline();
        test_pause();
        test_skip();
        test_restart();
        test_async_reset();
        test_zero_len_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
